// File: rtl/sparse_token_pkg.sv
// Shared token format, helpers and FSM encoding for the sparse fiber pipeline.
// Used by fiber_access, intersect and their benches.
package sparse_token_pkg;

    localparam int unsigned TOKEN_W    = 17;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned STOP_LVL_W = 8;
    localparam int unsigned CTRL_BIT   = 16;
    localparam int unsigned DONE_BIT   = 8;

    typedef logic [TOKEN_W-1:0] token_t;

    localparam token_t DONE_TOKEN = 17'h10100;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_RUN   = 2'd1,
        FSM_DRAIN = 2'd2
    } fsm_state_e;

    // One intersected beat: coordinate plus the matching position from each operand.
    typedef struct packed {
        token_t coord;
        token_t pos0;
        token_t pos1;
    } isect_beat_t;

    localparam int unsigned BEAT_W = $bits(isect_beat_t);

    function automatic logic is_ctrl(input token_t t);
        return t[CTRL_BIT];
    endfunction

    function automatic logic is_done(input token_t t);
        return t[CTRL_BIT] & t[DONE_BIT];
    endfunction

    function automatic logic is_stop(input token_t t);
        return t[CTRL_BIT] & ~t[DONE_BIT];
    endfunction

    function automatic logic [STOP_LVL_W-1:0] stop_lvl(input token_t t);
        return t[STOP_LVL_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] data_val(input token_t t);
        return t[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/stream_bcast_reg.sv
// One-entry register broadcasting a payload to N consumers, each with its own
// valid/ready; the entry frees once every consumer has taken it.
module stream_bcast_reg #(
    parameter int unsigned W     = 8,
    parameter int unsigned N_OUT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready_c,
    output logic [N_OUT-1:0] out_valid,
    input  logic [N_OUT-1:0] out_ready,
    output logic [W-1:0]     out_data
);

    // pend_q[i] is the complement of consumer i's sent bit while the entry is full.
    logic [N_OUT-1:0] pend_q;
    logic [N_OUT-1:0] pend_d;
    logic [N_OUT-1:0] left_c;
    logic [W-1:0]     data_q;
    logic [W-1:0]     data_d;

    always_comb begin
        left_c     = pend_q & ~out_ready;
        in_ready_c = clk_en & ~clear & ~(|left_c);
        pend_d     = pend_q;
        data_d     = data_q;
        if (clear) begin
            pend_d = '0;
            data_d = '0;
        end else if (clk_en) begin
            pend_d = left_c;
            if (in_valid && in_ready_c) begin
                pend_d = '1;
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

    assign out_valid = pend_q;
    assign out_data  = data_q;

endmodule

// File: rtl/intersect_unit_16.sv
// Sparse intersection of two (coord, pos) fiber streams; emits common coordinates
// with both operand positions and forwards STOP/DONE structure aligned.
module intersect_unit_16
    import sparse_token_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic               flush,
    input  logic               tile_en,
    input  logic [TOKEN_W-1:0] coord_in_0,
    input  logic               coord_in_0_valid,
    output logic               coord_in_0_ready,
    input  logic [TOKEN_W-1:0] coord_in_1,
    input  logic               coord_in_1_valid,
    output logic               coord_in_1_ready,
    input  logic [TOKEN_W-1:0] pos_in_0,
    input  logic               pos_in_0_valid,
    output logic               pos_in_0_ready,
    input  logic [TOKEN_W-1:0] pos_in_1,
    input  logic               pos_in_1_valid,
    output logic               pos_in_1_ready,
    output logic [TOKEN_W-1:0] coord_out,
    output logic               coord_out_valid,
    input  logic               coord_out_ready,
    output logic [TOKEN_W-1:0] pos_out_0,
    output logic               pos_out_0_valid,
    input  logic               pos_out_0_ready,
    output logic [TOKEN_W-1:0] pos_out_1,
    output logic               pos_out_1_valid,
    input  logic               pos_out_1_ready,
    output logic               error
);

    localparam int unsigned N_OUT = 3;

    fsm_state_e       state_q;
    fsm_state_e       state_d;
    logic             error_q;
    logic             error_d;

    logic             pres0_c;
    logic             pres1_c;
    logic             fire_c;
    logic             take0_c;
    logic             take1_c;
    logic             emit_c;
    logic             err_c;
    logic             done_c;
    isect_beat_t      beat_c;
    isect_beat_t      out_beat;
    logic             bc_ready_c;
    logic [N_OUT-1:0] bc_valid;
    logic [N_OUT-1:0] bc_ready;

    assign pres0_c = coord_in_0_valid & pos_in_0_valid;
    assign pres1_c = coord_in_1_valid & pos_in_1_valid;

    // Merge decision over the two side heads; only meaningful when both are present.
    always_comb begin
        take0_c     = 1'b0;
        take1_c     = 1'b0;
        emit_c      = 1'b0;
        err_c       = 1'b0;
        done_c      = 1'b0;
        beat_c.coord = coord_in_0;
        beat_c.pos0  = pos_in_0;
        beat_c.pos1  = pos_in_1;
        case ({is_ctrl(coord_in_0), is_ctrl(coord_in_1)})
            2'b00: begin
                if (data_val(coord_in_0) == data_val(coord_in_1)) begin
                    emit_c  = 1'b1;
                    take0_c = 1'b1;
                    take1_c = 1'b1;
                end else if (data_val(coord_in_0) < data_val(coord_in_1)) begin
                    take0_c = 1'b1;
                end else begin
                    take1_c = 1'b1;
                end
            end
            2'b01: take0_c = 1'b1;
            2'b10: take1_c = 1'b1;
            default: begin
                if (is_done(coord_in_0) && is_done(coord_in_1)) begin
                    emit_c       = 1'b1;
                    take0_c      = 1'b1;
                    take1_c      = 1'b1;
                    done_c       = 1'b1;
                    beat_c.coord = DONE_TOKEN;
                    beat_c.pos0  = DONE_TOKEN;
                    beat_c.pos1  = DONE_TOKEN;
                end else if (is_done(coord_in_0)) begin
                    take1_c = 1'b1;
                    err_c   = 1'b1;
                end else if (is_done(coord_in_1)) begin
                    take0_c = 1'b1;
                    err_c   = 1'b1;
                end else begin
                    // STOP/STOP: side-0's token goes out on all three outputs.
                    emit_c       = 1'b1;
                    take0_c      = 1'b1;
                    take1_c      = 1'b1;
                    err_c        = (stop_lvl(coord_in_0) != stop_lvl(coord_in_1));
                    beat_c.coord = coord_in_0;
                    beat_c.pos0  = coord_in_0;
                    beat_c.pos1  = coord_in_0;
                end
            end
        endcase
    end

    assign fire_c = pres0_c & pres1_c & (state_q == FSM_RUN) & tile_en & ~flush & bc_ready_c;

    assign coord_in_0_ready = fire_c & take0_c;
    assign pos_in_0_ready   = fire_c & take0_c;
    assign coord_in_1_ready = fire_c & take1_c;
    assign pos_in_1_ready   = fire_c & take1_c;

    assign bc_ready = {pos_out_1_ready, pos_out_0_ready, coord_out_ready} & {N_OUT{tile_en}};

    stream_bcast_reg #(
        .W     (BEAT_W),
        .N_OUT (N_OUT)
    ) u_bcast (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .clear      (flush),
        .in_valid   (fire_c & emit_c),
        .in_data    (beat_c),
        .in_ready_c (bc_ready_c),
        .out_valid  (bc_valid),
        .out_ready  (bc_ready),
        .out_data   (out_beat)
    );

    // Tile sequencing and sticky error.
    always_comb begin
        state_d = state_q;
        error_d = error_q;
        if (flush) begin
            state_d = FSM_IDLE;
            error_d = 1'b0;
        end else if (clk_en) begin
            if (fire_c && err_c) begin
                error_d = 1'b1;
            end
            case (state_q)
                FSM_IDLE:  if (tile_en) state_d = FSM_RUN;
                FSM_RUN:   if (fire_c && done_c) state_d = FSM_DRAIN;
                FSM_DRAIN: if (!(|bc_valid)) state_d = FSM_IDLE;
                default:   state_d = FSM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FSM_IDLE;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
        end
    end

    assign coord_out       = out_beat.coord;
    assign pos_out_0       = out_beat.pos0;
    assign pos_out_1       = out_beat.pos1;
    assign coord_out_valid = bc_valid[0] & tile_en;
    assign pos_out_0_valid = bc_valid[1] & tile_en;
    assign pos_out_1_valid = bc_valid[2] & tile_en;
    assign error           = error_q;

endmodule

// File: tb/tb_intersect_unit_16.sv
// Self-checking bench for intersect_unit_16 against a list-level merge model.
module tb_intersect_unit_16;
    import sparse_token_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n, clk_en, flush, tile_en;
    token_t coord_in_0, coord_in_1, pos_in_0, pos_in_1;
    logic   coord_in_0_valid, coord_in_1_valid, pos_in_0_valid, pos_in_1_valid;
    logic   coord_in_0_ready, coord_in_1_ready, pos_in_0_ready, pos_in_1_ready;
    token_t coord_out, pos_out_0, pos_out_1;
    logic   coord_out_valid, pos_out_0_valid, pos_out_1_valid;
    logic   coord_out_ready, pos_out_0_ready, pos_out_1_ready;
    logic   error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    intersect_unit_16 dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .coord_in_0(coord_in_0), .coord_in_0_valid(coord_in_0_valid), .coord_in_0_ready(coord_in_0_ready),
        .coord_in_1(coord_in_1), .coord_in_1_valid(coord_in_1_valid), .coord_in_1_ready(coord_in_1_ready),
        .pos_in_0(pos_in_0), .pos_in_0_valid(pos_in_0_valid), .pos_in_0_ready(pos_in_0_ready),
        .pos_in_1(pos_in_1), .pos_in_1_valid(pos_in_1_valid), .pos_in_1_ready(pos_in_1_ready),
        .coord_out(coord_out), .coord_out_valid(coord_out_valid), .coord_out_ready(coord_out_ready),
        .pos_out_0(pos_out_0), .pos_out_0_valid(pos_out_0_valid), .pos_out_0_ready(pos_out_0_ready),
        .pos_out_1(pos_out_1), .pos_out_1_valid(pos_out_1_valid), .pos_out_1_ready(pos_out_1_ready),
        .error(error)
    );

    token_t s0c[$], s0p[$], s1c[$], s1p[$];
    token_t ec[$], ep0[$], ep1[$];
    token_t oc[$], op0[$], op1[$];
    int     oc_cyc[$];
    logic   eerr;
    int     cyc = 0;
    bit     timed_out;
    int     split_viol, ce_viol;

    function automatic int first_diff(input token_t a[$], input token_t b[$]);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int k = 0; k < n; k++) if (a[k] !== b[k]) return k;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic token_t at_q(input token_t q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 'x;
    endfunction

    task automatic clear_streams();
        s0c.delete(); s0p.delete(); s1c.delete(); s1p.delete();
    endtask

    task automatic push_side(input int side, input token_t c, input token_t p);
        if (side == 0) begin s0c.push_back(c); s0p.push_back(p); end
        else           begin s1c.push_back(c); s1p.push_back(p); end
    endtask

    // Position = coord + 0x10 for data; control tokens travel on both streams.
    task automatic push_plain(input int side, input token_t c);
        push_side(side, c, c[16] ? c : token_t'(c + 17'h10));
    endtask

    task automatic set_expect3(input token_t v[$]);
        ec = v; ep0 = v; ep1 = v;
    endtask

    task automatic push3(input token_t a, input token_t b, input token_t c);
        ec.push_back(a); ep0.push_back(b); ep1.push_back(c);
    endtask

    // Reference: walk both token lists under the intersection rules.
    task automatic build_expect();
        int i = 0;
        int j = 0;
        token_t a, b;
        ec.delete(); ep0.delete(); ep1.delete(); eerr = 1'b0;
        while (i < s0c.size() && j < s1c.size()) begin
            a = s0c[i]; b = s1c[j];
            if (!a[16] && !b[16]) begin
                if (a[15:0] == b[15:0]) begin push3(a, s0p[i], s1p[j]); i++; j++; end
                else if (a[15:0] < b[15:0]) i++;
                else j++;
            end else if (!a[16]) i++;
            else if (!b[16]) j++;
            else if (a[8] && b[8]) begin push3(DONE_TOKEN, DONE_TOKEN, DONE_TOKEN); break; end
            else if (a[8]) begin j++; eerr = 1'b1; end
            else if (b[8]) begin i++; eerr = 1'b1; end
            else begin
                push3(a, a, a);
                if (a[7:0] != b[7:0]) eerr = 1'b1;
                i++; j++;
            end
        end
    endtask

    task automatic drop_inputs();
        coord_in_0_valid = 0; pos_in_0_valid = 0; coord_in_1_valid = 0; pos_in_1_valid = 0;
        coord_in_0 = '0; pos_in_0 = '0; coord_in_1 = '0; pos_in_1 = '0;
        coord_out_ready = 1; pos_out_0_ready = 1; pos_out_1_ready = 1; clk_en = 1;
    endtask

    // Drive both sides from the stream queues and collect output handshakes.
    task automatic run_tile(input int in_mode, input int out_mode, input bit ce_mode,
                            input bit stop_first, input int max_cyc);
        int  i0 = 0;
        int  i1 = 0;
        int  n  = 0;
        bit  h0, h1, broke;
        broke = 0;
        oc.delete(); op0.delete(); op1.delete(); oc_cyc.delete();
        split_viol = 0; ce_viol = 0; timed_out = 1;
        while (n < max_cyc) begin
            @(negedge clk);
            clk_en = ce_mode ? 1'($urandom_range(1)) : 1'b1;
            coord_in_0_valid = 0; pos_in_0_valid = 0; coord_in_1_valid = 0; pos_in_1_valid = 0;
            if (i0 < s0c.size()) begin
                coord_in_0 = s0c[i0]; pos_in_0 = s0p[i0];
                coord_in_0_valid = (in_mode == 0) || ($urandom_range(3) != 0);
                pos_in_0_valid   = (in_mode == 0) || ($urandom_range(3) != 0);
            end
            if (i1 < s1c.size()) begin
                coord_in_1 = s1c[i1]; pos_in_1 = s1p[i1];
                coord_in_1_valid = (in_mode == 0) || ($urandom_range(3) != 0);
                pos_in_1_valid   = (in_mode == 0) || ($urandom_range(3) != 0);
            end
            case (out_mode)
                1: begin coord_out_ready = 1; pos_out_0_ready = 1; pos_out_1_ready = ((cyc / 2) % 2) == 0; end
                2: begin
                    coord_out_ready = 1'($urandom_range(1));
                    pos_out_0_ready = 1'($urandom_range(1));
                    pos_out_1_ready = 1'($urandom_range(1));
                end
                default: begin coord_out_ready = 1; pos_out_0_ready = 1; pos_out_1_ready = 1; end
            endcase
            if (!clk_en) begin coord_out_ready = 0; pos_out_0_ready = 0; pos_out_1_ready = 0; end
            #1;
            if (coord_in_0_ready !== pos_in_0_ready || coord_in_1_ready !== pos_in_1_ready) split_viol++;
            if (!clk_en && (coord_in_0_ready || coord_in_1_ready || pos_in_0_ready || pos_in_1_ready)) ce_viol++;
            h0 = coord_in_0_ready && coord_in_0_valid && pos_in_0_valid;
            h1 = coord_in_1_ready && coord_in_1_valid && pos_in_1_valid;
            if (coord_out_valid && coord_out_ready) begin oc.push_back(coord_out); oc_cyc.push_back(cyc); end
            if (pos_out_0_valid && pos_out_0_ready) op0.push_back(pos_out_0);
            if (pos_out_1_valid && pos_out_1_ready) op1.push_back(pos_out_1);
            if (stop_first && oc.size() > 0) begin broke = 1; timed_out = 0; break; end
            @(posedge clk);
            if (h0) i0++;
            if (h1) i1++;
            cyc++; n++;
            if (oc.size() >= ec.size() && op0.size() >= ep0.size() && op1.size() >= ep1.size()) begin
                timed_out = 0;
                break;
            end
        end
        if (!broke) @(negedge clk);
        drop_inputs();
    endtask

    task automatic check_outputs(input string tag);
        int d;
        total++;
        if (timed_out) begin bad++; $display("FAIL %s timeout got=%0d/%0d tokens", tag, oc.size(), ec.size()); end
        d = first_diff(oc, ec); total++;
        if (d >= 0) begin bad++; $display("FAIL %s coord_out idx=%0d got=%h exp=%h n=%0d/%0d", tag, d, at_q(oc, d), at_q(ec, d), oc.size(), ec.size()); end
        d = first_diff(op0, ep0); total++;
        if (d >= 0) begin bad++; $display("FAIL %s pos_out_0 idx=%0d got=%h exp=%h n=%0d/%0d", tag, d, at_q(op0, d), at_q(ep0, d), op0.size(), ep0.size()); end
        d = first_diff(op1, ep1); total++;
        if (d >= 0) begin bad++; $display("FAIL %s pos_out_1 idx=%0d got=%h exp=%h n=%0d/%0d", tag, d, at_q(op1, d), at_q(ep1, d), op1.size(), ep1.size()); end
    endtask

    task automatic set_basic();
        token_t c0[$] = '{17'd1, 17'd3, 17'd5, 17'h10000, 17'h10100};
        token_t c1[$] = '{17'd3, 17'd4, 17'd5, 17'h10000, 17'h10100};
        clear_streams();
        foreach (c0[k]) push_plain(0, c0[k]);
        foreach (c1[k]) push_plain(1, c1[k]);
        ec  = '{17'd3, 17'd5, 17'h10000, 17'h10100};
        ep0 = '{17'h13, 17'h15, 17'h10000, 17'h10100};
        ep1 = '{17'h13, 17'h15, 17'h10000, 17'h10100};
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; tile_en = 1; drop_inputs();
        coord_in_0 = 17'd5; pos_in_0 = 17'd5; coord_in_1 = 17'd5; pos_in_1 = 17'd5;
        coord_in_0_valid = 1; pos_in_0_valid = 1; coord_in_1_valid = 1; pos_in_1_valid = 1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({coord_out_valid, pos_out_0_valid, pos_out_1_valid} !== 3'b000) begin
            bad++; $display("FAIL reset valids got=%b exp=000", {coord_out_valid, pos_out_0_valid, pos_out_1_valid});
        end
        total++;
        if ({coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready} !== 4'b0000) begin
            bad++; $display("FAIL reset readies got=%b exp=0000", {coord_in_0_ready, pos_in_0_ready, coord_in_1_ready, pos_in_1_ready});
        end
        total++;
        if ({coord_out, pos_out_0, pos_out_1} !== 51'h0) begin
            bad++; $display("FAIL reset outputs got=%h/%h/%h exp=0", coord_out, pos_out_0, pos_out_1);
        end
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL reset error got=%b exp=0", error); end
        @(negedge clk);
        rst_n = 1; drop_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_match();
        set_basic();
        run_tile(1, 0, 0, 0, 300);
        check_outputs("basic");
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL basic error got=%b exp=0", error); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_empty();
        clear_streams();
        push_plain(0, 17'd2); push_plain(0, 17'h10000); push_plain(0, DONE_TOKEN);
        push_plain(1, 17'd7); push_plain(1, 17'h10000); push_plain(1, DONE_TOKEN);
        set_expect3('{17'h10000, 17'h10100});
        run_tile(1, 0, 0, 0, 300);
        check_outputs("empty");
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL empty error got=%b exp=0", error); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        set_basic();
        run_tile(0, 1, 0, 0, 300);
        check_outputs("backpressure");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stop_mismatch();
        clear_streams();
        push_plain(0, 17'h10001); push_plain(0, DONE_TOKEN);
        push_plain(1, 17'h10000); push_plain(1, DONE_TOKEN);
        set_expect3('{17'h10001, 17'h10100});
        run_tile(0, 0, 0, 0, 300);
        check_outputs("stop_mismatch");
        repeat (4) @(negedge clk);
        total++;
        if (error !== 1'b1) begin bad++; $display("FAIL stop_mismatch sticky error got=%b exp=1", error); end
        flush = 1;
        @(negedge clk);
        flush = 0;
        #1;
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL flush clears error got=%b exp=0", error); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        set_basic();
        run_tile(0, 0, 0, 1, 300);
        total++;
        if (timed_out) begin bad++; $display("FAIL mid_reset first match got=none exp=one"); end
        rst_n = 0;
        #1;
        total++;
        if ({coord_out_valid, pos_out_0_valid, pos_out_1_valid} !== 3'b000) begin
            bad++; $display("FAIL mid_reset valids got=%b exp=000", {coord_out_valid, pos_out_0_valid, pos_out_1_valid});
        end
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        set_basic();
        run_tile(1, 2, 0, 0, 400);
        check_outputs("after_reset");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_throughput();
        clear_streams();
        for (int v = 1; v <= 8; v++) begin push_plain(0, token_t'(v)); push_plain(1, token_t'(v)); end
        push_plain(0, 17'h10000); push_plain(0, DONE_TOKEN);
        push_plain(1, 17'h10000); push_plain(1, DONE_TOKEN);
        build_expect();
        run_tile(0, 0, 0, 0, 300);
        check_outputs("throughput");
        total++;
        if (oc_cyc.size() < 8 || (oc_cyc[7] - oc_cyc[0]) != 7) begin
            bad++; $display("FAIL throughput span got=%0d exp=7", (oc_cyc.size() < 8) ? -1 : oc_cyc[7] - oc_cyc[0]);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic gen_random(input int seed_tag);
        int nf = $urandom_range(3, 1);
        int p0 = 0;
        int p1 = 0;
        logic [15:0] base;
        clear_streams();
        for (int f = 0; f < nf; f++) begin
            case ($urandom_range(2))
                0:       base = 16'h0000;
                1:       base = 16'h7FF8;
                default: base = 16'hFFF0;
            endcase
            for (int v = 0; v < 16; v++) begin
                if ($urandom_range(1) == 1) begin push_side(0, {1'b0, 16'(base + 16'(v))}, token_t'(16'h100 + 16'(p0))); p0++; end
                if ($urandom_range(1) == 1) begin push_side(1, {1'b0, 16'(base + 16'(v))}, token_t'(16'h800 + 16'(p1))); p1++; end
            end
            push_plain(0, token_t'(17'h10000 + 17'(f))); push_plain(1, token_t'(17'h10000 + 17'(f)));
        end
        push_plain(0, DONE_TOKEN); push_plain(1, DONE_TOKEN);
        if (seed_tag < 0) clear_streams();
    endtask

    task automatic test_clk_en();
        gen_random(0);
        build_expect();
        run_tile(1, 0, 1, 0, 2000);
        check_outputs("clk_en");
        total++;
        if (ce_viol != 0) begin bad++; $display("FAIL clk_en readies got=%0d cycles high exp=0", ce_viol); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int splits = 0;
        for (int it = 0; it < 6; it++) begin
            gen_random(it);
            build_expect();
            run_tile(1, 2, 0, 0, 3000);
            check_outputs("random");
            splits += split_viol;
            total++;
            if (error !== eerr) begin bad++; $display("FAIL random error got=%b exp=%b", error, eerr); end
            repeat (3) @(negedge clk);
        end
        total++;
        if (splits != 0) begin bad++; $display("FAIL side ready split got=%0d exp=0", splits); end
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_empty();
        test_backpressure();
        test_stop_mismatch();
        test_mid_reset();
        test_throughput();
        test_clk_en();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
